dcache_line_reader: RTL and testbench
=====================================

DCACHE_LINE_READER -- requirements
Module: dcache_line_reader

Interface
REQ-001 Parameter: ADDR_W, default 32, width of the memory-bus address.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to write back one 32-byte cache line; sampled only in IDLE.
REQ-005 Port: line_addr  input  ADDR_W  byte address of the line; bits [4:0] ignored.
REQ-006 Port: busy  output  1  high whenever the state is not IDLE.
REQ-007 Port: done  output  1  one-cycle pulse after the last word is accepted.
REQ-008 Port: ram_raddr  output  5  byte read address into the 32x8 line RAM.
REQ-009 Port: ram_dataout  input  8  line RAM read data, valid combinationally in the same cycle as ram_raddr.
REQ-010 Port: mem_valid  output  1  write-word request toward the memory bus.
REQ-011 Port: mem_ready  input  1  memory bus accepts the word.
REQ-012 Port: mem_addr  output  ADDR_W  word byte address: {line_addr[ADDR_W-1:5], word_idx[2:0], 2'b00}.
REQ-013 Port: mem_wdata  output  32  assembled word, little-endian.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, GATHER, SEND and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch line_addr[ADDR_W-1:5], clear word_idx and byte_idx, and enter GATHER.
REQ-016 In GATHER, ram_raddr SHALL equal {word_idx, byte_idx}; each edge stores ram_dataout into mem_wdata[8*byte_idx+7 : 8*byte_idx] and increments byte_idx.
REQ-017 After the edge that captures byte_idx=3, the FSM SHALL enter SEND, with byte_idx wrapping to 0.
REQ-018 In SEND, mem_valid SHALL be 1, and mem_addr and mem_wdata SHALL stay stable until mem_valid&mem_ready is seen at an edge.
REQ-019 On transfer with word_idx<7, word_idx SHALL increment and the FSM SHALL return to GATHER; with word_idx=7, the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Minimum latency with mem_ready held high: first mem_valid in cycle 5 after the start edge; 40 cycles of GATHER/SEND in total; done in cycle 41.
REQ-022 mem_valid SHALL be 0 in every state except SEND; done SHALL be 0 in every state except DONE.
REQ-023 start while busy=1, including during DONE, SHALL be ignored and not queued.
REQ-024 mem_ready while not in SEND SHALL have no effect.
REQ-025 In IDLE and DONE, ram_raddr SHALL be 0.
REQ-026 The word and byte counters SHALL never exceed 7 and 3; the transfer order is strictly words 0..7, bytes 0..3.
REQ-027 The block SHALL never issue more than 8 transfers per start.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, mem_valid=0, ram_raddr=0, mem_addr=0, mem_wdata=0, and clear all counters.
REQ-029 Reset asserted mid-line SHALL abort the line with no further transfers; after release the block SHALL wait in IDLE for a new start.
REQ-030 The first start is honoured at the first rising edge after reset_n deasserts.

Verification
REQ-031 RAM preset byte[i]=i, line_addr=0x1000_0040, start pulse, mem_ready=1 -> words 0x03020100 @0x10000040 through 0x1F1E1D1C @0x1000005C, done in cycle 41.
REQ-032 Same stimulus with mem_ready low for 3 cycles in each SEND -> mem_addr and mem_wdata held stable, still exactly 8 transfers, done once.
REQ-033 line_addr=0x0000_007F -> first mem_addr is 0x00000060 (low bits ignored).
REQ-034 start pulsed again during GATHER and during DONE -> ignored; exactly 8 transfers, and IDLE is reached after the single done.
REQ-035 reset_n pulsed low during SEND of word 3 -> mem_valid and busy drop at once; no done; a new start gives a clean 8-word sequence.
REQ-036 mem_ready held high in IDLE and GATHER -> no transfer counted and mem_valid stays 0.

Source files
------------

// File: rtl/dcache_line_reader.sv
// Reads one 32-byte line out of a byte-wide line RAM and writes it to the
// memory bus as eight little-endian 32-bit words, words 0..7 in order.
module dcache_line_reader #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] line_addr,
   output logic              busy,
   output logic              done,
   output logic [4:0]        ram_raddr,
   input  logic [7:0]        ram_dataout,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATHER = 2'd1,
      SEND   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-6:0] line_tag;
   logic [2:0]        word_idx;
   logic [1:0]        byte_idx;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = GATHER;
         GATHER:  if (byte_idx == 2'd3) state_nxt = SEND;
         SEND:    if (mem_ready) state_nxt = (word_idx == 3'd7) ? DONE : GATHER;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      mem_valid = (state == SEND);
      ram_raddr = (state == GATHER) ? {word_idx, byte_idx} : 5'd0;
   end

   // The counters only move in GATHER and on an accepted SEND, so the word stays put while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_tag  <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  line_tag <= line_addr[ADDR_W-1:5];
                  word_idx <= '0;
                  byte_idx <= '0;
               end
            end
            GATHER: begin
               mem_wdata[{byte_idx, 3'b000} +: 8] <= ram_dataout;
               byte_idx <= byte_idx + 2'd1;
            end
            SEND: begin
               if (mem_ready && (word_idx != 3'd7)) word_idx <= word_idx + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign mem_addr = {line_tag, word_idx, 2'b00};

endmodule

// File: tb/tb_dcache_line_reader.sv
// Bench for dcache_line_reader: a table of line scenarios plus hand-written
// sequences for start-while-busy and reset-mid-line; a queue scoreboards transfers.
module tb_dcache_line_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] line_addr;
   logic        busy;
   logic        done;
   logic [4:0]  ram_raddr;
   logic [7:0]  ram_dataout;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   logic [7:0]  ram [32];
   assign ram_dataout = ram[ram_raddr];

   dcache_line_reader #(.ADDR_W(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .line_addr   (line_addr),
      .busy        (busy),
      .done        (done),
      .ram_raddr   (ram_raddr),
      .ram_dataout (ram_dataout),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata)
   );

   typedef struct {
      logic [31:0] line_addr;
      int          stall;
      bit          force_rdy;
      logic [7:0]  seed;
      logic [31:0] first_addr;
      logic [31:0] last_addr;
      logic [31:0] first_data;
      logic [31:0] last_data;
      int          done_rel;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   xfer_t       exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          xfer_cnt = 0;
   int          done_cnt = 0;
   int          done_rel = -1;
   int          first_valid_rel = -1;
   int          ready_stall = 0;
   bit          force_ready = 1'b0;
   logic [31:0] first_addr, last_addr, first_data, last_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Monitor and mem_ready driver: samples on the falling edge, then sets mem_ready for the coming edge.
   initial begin : monitor
      int          wait_cnt;
      bit          prev_hold;
      logic [31:0] prev_addr, prev_data;
      xfer_t       e;
      wait_cnt  = 0;
      prev_hold = 1'b0;
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            prev_hold = 1'b0;
         end else begin
            if (start && !busy) start_cyc = cyc;
            if (mem_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
            if (done) begin
               done_cnt++;
               done_rel = cyc - start_cyc;
               check("done_without_valid", mem_valid, 0);
            end
            if (prev_hold) begin
               check("hold_valid", mem_valid, 1);
               check("hold_addr", mem_addr, prev_addr);
               check("hold_wdata", mem_wdata, prev_data);
            end
            if (force_ready) begin
               mem_ready = 1'b1;
            end else if (mem_valid) begin
               mem_ready = (wait_cnt >= ready_stall);
               wait_cnt++;
            end else begin
               mem_ready = 1'b0;
               wait_cnt  = 0;
            end
            if (mem_valid && mem_ready) begin
               xfer_cnt++;
               check("xfer_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("xfer_addr", mem_addr, e.addr);
                  check("xfer_wdata", mem_wdata, e.data);
               end
               if (xfer_cnt == 1) begin
                  first_addr = mem_addr;
                  first_data = mem_wdata;
               end
               last_addr = mem_addr;
               last_data = mem_wdata;
            end
            prev_hold = mem_valid && !mem_ready;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
         end
      end
   end

   // Called just after a rising edge; start is high for exactly the next edge.
   task automatic start_line(input vec_t v);
      xfer_t e;
      for (int i = 0; i < 32; i++) ram[i] = 8'(i) ^ v.seed;
      ready_stall     = v.stall;
      force_ready     = v.force_rdy;
      xfer_cnt        = 0;
      done_cnt        = 0;
      done_rel        = -1;
      first_valid_rel = -1;
      for (int w = 0; w < 8; w++) begin
         e.addr = {v.line_addr[31:5], 3'(w), 2'b00};
         e.data = {ram[4*w+3], ram[4*w+2], ram[4*w+1], ram[4*w]};
         exp_q.push_back(e);
      end
      line_addr = v.line_addr;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_line(input vec_t v, input bit inject);
      bit done_seen;
      start_line(v);
      done_seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (done) begin
            done_seen = 1'b1;
            break;
         end
         start = inject && (i == 1);
      end
      check("done_seen", done_seen, 1);
      start = inject;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_after_done", busy, 0);
      check("done_pulse_width", done, 0);
      check("done_cycle", done_rel, v.done_rel);
      check("first_valid_cycle", first_valid_rel, 5);
      check("xfer_count", xfer_cnt, 8);
      check("first_addr", first_addr, v.first_addr);
      check("last_addr", last_addr, v.last_addr);
      check("first_wdata", first_data, v.first_data);
      check("last_wdata", last_data, v.last_data);
      check("scoreboard_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      check("still_idle", busy, 0);
      check("done_count", done_cnt, 1);
      check("idle_raddr", ram_raddr, 0);
   endtask

   initial begin : main
      vec_t vecs[5];
      vec_t v;
      bit   found;

      vecs[0] = '{32'h1000_0040, 0, 1'b1, 8'h00, 32'h1000_0040, 32'h1000_005C,
                  32'h0302_0100, 32'h1F1E_1D1C, 41};
      vecs[1] = '{32'h1000_0040, 3, 1'b0, 8'h00, 32'h1000_0040, 32'h1000_005C,
                  32'h0302_0100, 32'h1F1E_1D1C, 65};
      vecs[2] = '{32'h0000_007F, 0, 1'b1, 8'h00, 32'h0000_0060, 32'h0000_007C,
                  32'h0302_0100, 32'h1F1E_1D1C, 41};
      vecs[3] = '{32'hABCD_EF1F, 1, 1'b0, 8'hFF, 32'hABCD_EF00, 32'hABCD_EF1C,
                  32'hFCFD_FEFF, 32'hE0E1_E2E3, 49};
      vecs[4] = '{32'hFFFF_FFE5, 2, 1'b0, 8'hA5, 32'hFFFF_FFE0, 32'hFFFF_FFFC,
                  32'hA6A7_A4A5, 32'hBABB_B8B9, 57};

      reset_n   = 1'b0;
      start     = 1'b0;
      line_addr = 32'h0;
      for (int i = 0; i < 32; i++) ram[i] = 8'(i);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", mem_valid, 0);
      check("rst_raddr", ram_raddr, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // mem_ready high while idle must not produce transfers.
      force_ready = 1'b1;
      line_addr   = 32'h5555_5555;
      repeat (5) @(posedge clk);
      #1;
      check("idle_ready_xfers", xfer_cnt, 0);
      check("idle_ready_valid", mem_valid, 0);
      check("idle_ready_busy", busy, 0);

      for (int i = 0; i < 5; i++) run_line(vecs[i], 1'b0);

      // start pulses during GATHER and during DONE are ignored.
      run_line(vecs[0], 1'b1);

      // Reset while word 3 is stalled in SEND.
      v = vecs[1];
      start_line(v);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (mem_valid && xfer_cnt == 3) begin
            found = 1'b1;
            break;
         end
      end
      check("word3_send_seen", found, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_valid", mem_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_wdata", mem_wdata, 0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_xfers", xfer_cnt, 3);
      check("abort_no_done", done_cnt, 0);
      check("abort_pending", exp_q.size(), 5);
      exp_q.delete();
      reset_n = 1'b1;
      run_line(vecs[0], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
